// File: rtl/ps2_key_writer.sv
// ----------------------------------------------------------------------------
// ps2_key_writer
//   Receives PS/2 keyboard frames, folds E0 (extended) and F0 (break) prefixes
//   into flags, and writes one key word per key event into a circular buffer
//   held in a dual-port RAM (port b). After every key word, the write-index
//   word is updated so software polling port a can detect new keys.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   ps2_clk    in   raw PS/2 clock (asynchronous, idles high)
//   ps2_data   in   raw PS/2 data (asynchronous, idles high)
//   grant      in   port-b access granted this cycle
//   addr_b     out  RAM port-b address
//   data_b     out  RAM port-b write data
//   we_b       out  RAM port-b write enable (registered)
//   frame_err  out  one-cycle pulse on a rejected frame (parity/stop/timeout)
//   overflow   out  sticky: a key word was dropped because the hold was full
// ----------------------------------------------------------------------------
module ps2_key_writer #(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 10,
  parameter logic [ADDR_WIDTH-1:0] BUF_BASE       = 10'h3C0,
  parameter int                    BUF_DEPTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] PTR_ADDR       = 10'h3BF,
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  grant,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic                  we_b,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic       {R_IDLE, R_RECV}         rx_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_PTR}  wr_state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers and falling-edge detect. The flops reset to 1 (the
  // bus idle level) so leaving reset never fakes a falling edge.
  // --------------------------------------------------------------------------
  logic r_clk_s1, r_clk_s2, r_clk_prev;
  logic r_dat_s1, r_dat_s2;
  logic w_fall;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would chain the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  rx_state_t        r_rx_state, w_rx_next;
  logic [3:0]       r_bit_cnt;   // index of the next bit to arrive (1..10)
  logic [8:0]       r_shift;     // {parity, data[7:0]} after nine shifts
  logic [TMR_W-1:0] r_timer;
  logic             r_frame_err;
  logic             w_deliver, w_err;
  logic [7:0]       w_byte;

  assign w_byte = r_shift[7:0];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_rx_next = r_rx_state;
    w_deliver = 1'b0;
    w_err     = 1'b0;
    case (r_rx_state)
      R_IDLE: if (w_fall && !r_dat_s2) w_rx_next = R_RECV;
      R_RECV: begin
        if (w_fall) begin
          if (r_bit_cnt == 4'd10) begin
            w_rx_next = R_IDLE;
            // Odd parity over data+parity, and stop must be high.
            if ((^r_shift) && r_dat_s2) w_deliver = 1'b1;
            else                        w_err     = 1'b1;
          end
        end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          w_err     = 1'b1;
          w_rx_next = R_IDLE;
        end
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state  <= R_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_timer     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_state  <= w_rx_next;
      r_frame_err <= w_err;
      if (w_fall || r_rx_state == R_IDLE) r_timer <= '0;
      else                                r_timer <= r_timer + 1'b1;
      if (w_fall) begin
        if (r_rx_state == R_IDLE) begin
          r_bit_cnt <= 4'd1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
          // LSB-first: shift in at the top so bit 1 ends up at position 0.
          if (r_bit_cnt <= 4'd9) r_shift <= {r_dat_s2, r_shift[8:1]};
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Prefix decode and single-entry hold register
  // --------------------------------------------------------------------------
  wr_state_t             r_wr_state, w_wr_next;
  logic                  r_ext, r_brk;
  logic                  r_hold_full, r_overflow;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  w_is_prefix, w_key_valid, w_hold_free, w_hold_load;

  assign w_is_prefix = (w_byte == 8'hE0) || (w_byte == 8'hF0);
  assign w_key_valid = w_deliver && !w_is_prefix;
  assign w_hold_free = (r_wr_state == W_PTR) && grant;
  assign w_hold_load = w_key_valid && (!r_hold_full || w_hold_free);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_deliver) begin
        if (w_byte == 8'hE0)      r_ext <= 1'b1;
        else if (w_byte == 8'hF0) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
      if (w_hold_load) begin
        r_hold      <= DATA_WIDTH'({r_ext, r_brk, w_byte});
        r_hold_full <= 1'b1;
      end else if (w_hold_free) begin
        r_hold_full <= 1'b0;
      end
      if (w_key_valid && !w_hold_load) r_overflow <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM: key word, then write-index word, each on a granted cycle.
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_we;

  // BUF_DEPTH is a power of two, so the natural wrap of IDX_W bits is the
  // modulo the buffer needs.
  assign w_idx_next = r_idx + IDX_W'(1);

  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      W_IDLE:  if (r_hold_full) w_wr_next = W_DATA;
      W_DATA:  if (grant)       w_wr_next = W_PTR;
      W_PTR:   if (grant)       w_wr_next = W_IDLE;
      default:                  w_wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_state <= W_IDLE;
      r_idx      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_we       <= 1'b0;
    end else begin
      r_wr_state <= w_wr_next;
      r_we       <= 1'b0;
      if (grant) begin
        if (r_wr_state == W_DATA) begin
          r_addr <= BUF_BASE + ADDR_WIDTH'(r_idx);
          r_data <= r_hold;
          r_we   <= 1'b1;
        end else if (r_wr_state == W_PTR) begin
          r_addr <= PTR_ADDR;
          r_data <= DATA_WIDTH'(w_idx_next);
          r_we   <= 1'b1;
          r_idx  <= w_idx_next;
        end
      end
    end
  end

  assign addr_b    = r_addr;
  assign data_b    = r_data;
  assign we_b      = r_we;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_writer.sv
module tb_ps2_key_writer;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        grant = 1'b1;
  logic [9:0]  addr_b;
  logic [15:0] data_b;
  logic        we_b;
  logic        frame_err;
  logic        overflow;

  ps2_key_writer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .grant(grant), .addr_b(addr_b), .data_b(data_b), .we_b(we_b),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_fall = 0;
  int  we_count = 0;
  int  fe_count = 0;
  logic fe_prev = 1'b0;

  // Bench-side reference state for key-word formation.
  int  m_idx = 0;
  bit  m_ext = 0, m_brk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [9:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Expected RAM traffic for one delivered byte.
  task automatic model_byte(input logic [7:0] b);
    logic [15:0] key;
    if (b == 8'hE0)      m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      key = {6'b0, m_ext, m_brk, b};
      expect_wr(10'h3C0 + 10'(m_idx), key);
      m_idx = (m_idx + 1) % 32;
      expect_wr(10'h3BF, 16'(m_idx));
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // Monitor: pops the scoreboard on every write, tracks frame_err pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (we_b) begin
        wr_t w;
        we_count++;
        check("write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("addr_b", 32'(addr_b), 32'(w.addr));
          check("data_b", 32'(data_b), 32'(w.data));
        end
      end
      if (frame_err) begin
        fe_count++;
        check("frame_err_one_cycle", 32'(fe_prev), 32'd0);
      end
      fe_prev = frame_err;
    end else begin
      fe_prev = 1'b0;
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(bits, 11);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr_b", 32'(addr_b), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_we_b", 32'(we_b), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    m_idx = 0;
    m_ext = 0;
    m_brk = 0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int fe_before, we_before, delta, n;
    apply_reset();

    // Single make code, hand-computed traffic.
    expect_wr(10'h3C0, 16'h001C);
    expect_wr(10'h3BF, 16'h0001);
    m_idx = 1;
    send_frame(8'h1C, 0);
    drain("drain_1c");
    check("no_err_after_good", 32'(fe_count), 32'd0);

    // Break code and extended break code.
    expect_wr(10'h3C1, 16'h011C);
    expect_wr(10'h3BF, 16'h0002);
    m_idx = 2;
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    drain("drain_f0_1c");
    expect_wr(10'h3C2, 16'h0374);
    expect_wr(10'h3BF, 16'h0003);
    m_idx = 3;
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h74, 0);
    drain("drain_e0_f0_74");

    // Bad parity: one error pulse, nothing written; next frame fine.
    fe_before = fe_count;
    we_before = we_count;
    send_frame(8'h1C, 1);
    repeat (20) @(negedge clk);
    check("parity_err_pulse", 32'(fe_count - fe_before), 32'd1);
    check("parity_no_write", 32'(we_count - we_before), 32'd0);
    model_byte(8'h5A);
    send_frame(8'h5A, 0);
    drain("drain_after_parity");

    // Five bits then silence: timeout error after TMO idle cycles.
    fe_before = fe_count;
    send_bits(11'b000_1011_1000, 5);
    n = 0;
    while (!frame_err && n < TMO + 100) begin
      @(negedge clk);
      n++;
    end
    delta = cyc - last_fall;
    checks++;
    if (!frame_err || delta < TMO || delta > TMO + 4) begin
      errors++;
      $display("FAIL timeout_delay actual=%0d required=%0d..%0d", delta, TMO, TMO + 4);
    end
    repeat (5) @(negedge clk);
    check("timeout_err_count", 32'(fe_count - fe_before), 32'd1);
    model_byte(8'h29);
    send_frame(8'h29, 0);
    drain("drain_after_timeout");

    // Wrap: 33 keys from index 0.
    apply_reset();
    for (int c = 1; c <= 33; c++) begin
      model_byte(8'(c));
      send_frame(8'(c), 0);
    end
    drain("drain_wrap");
    check("overflow_clear", 32'(overflow), 32'd0);

    // Stalled port: hold fills, second key dropped, then release.
    grant = 1'b0;
    we_before = we_count;
    send_frame(8'h15, 0);
    repeat (100) @(negedge clk);
    check("stall_no_we", 32'(we_count - we_before), 32'd0);
    check("stall_no_overflow", 32'(overflow), 32'd0);
    send_frame(8'h16, 0);
    repeat (10) @(negedge clk);
    check("overflow_set", 32'(overflow), 32'd1);
    check("stall_still_no_we", 32'(we_count - we_before), 32'd0);
    expect_wr(10'h3C1, 16'h0015);
    expect_wr(10'h3BF, 16'h0002);
    m_idx = 2;
    grant = 1'b1;
    drain("drain_after_stall");
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset in the middle of a frame, then a clean frame from index 0.
    send_bits(11'b000_0101_0100, 4);
    apply_reset();
    expect_wr(10'h3C0, 16'h002A);
    expect_wr(10'h3BF, 16'h0001);
    m_idx = 1;
    send_frame(8'h2A, 0);
    drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
